// File: rtl/arb_pkg.sv
// Shared types and helpers for the 8-way round-robin grant arbiter.
package arb_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned SEL_W = 3;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StGrant = 2'd1,
    StGuard = 2'd2
  } state_e;

  // First set request strictly after `last`, wrapping modulo N_REQ; `last` itself is checked last.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                input logic [SEL_W-1:0] last);
    logic [SEL_W-1:0] pick;
    logic [SEL_W-1:0] idx;
    logic             found;
    pick  = last;
    found = 1'b0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      idx = last + SEL_W'(i);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/_3to8decoder.sv
// Plain 3-to-8 one-hot decoder: D2..D0 select which OUTn is high.
module _3to8decoder (
  input  logic D2,
  input  logic D1,
  input  logic D0,
  output logic OUT7,
  output logic OUT6,
  output logic OUT5,
  output logic OUT4,
  output logic OUT3,
  output logic OUT2,
  output logic OUT1,
  output logic OUT0
);

  logic [2:0] d;

  assign d    = {D2, D1, D0};
  assign OUT0 = (d == 3'd0);
  assign OUT1 = (d == 3'd1);
  assign OUT2 = (d == 3'd2);
  assign OUT3 = (d == 3'd3);
  assign OUT4 = (d == 3'd4);
  assign OUT5 = (d == 3'd5);
  assign OUT6 = (d == 3'd6);
  assign OUT7 = (d == 3'd7);

endmodule

// File: rtl/decoder_grant_arbiter.sv
// 8-way round-robin arbiter: registered winner index, decoded one-hot grant gated by state,
// per-grant hold timeout and a guard gap between consecutive grants.
module decoder_grant_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD     = 16,
  parameter int unsigned GUARD_CYCLES = 1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] REQ,
  output logic [7:0] GNT,
  output logic [2:0] SEL,
  output logic       BUSY,
  output logic       TIMEOUT
);

  localparam int unsigned HoldW  = $clog2(MAX_HOLD + 1);
  localparam int unsigned GuardW = $clog2(GUARD_CYCLES + 1);

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic [GuardW-1:0] guard_q, guard_d;
  logic              timeout_q, timeout_d;
  logic [N_REQ-1:0]  dec_raw;

  _3to8decoder u_dec (
    .D2  (sel_q[2]),
    .D1  (sel_q[1]),
    .D0  (sel_q[0]),
    .OUT7(dec_raw[7]),
    .OUT6(dec_raw[6]),
    .OUT5(dec_raw[5]),
    .OUT4(dec_raw[4]),
    .OUT3(dec_raw[3]),
    .OUT2(dec_raw[2]),
    .OUT1(dec_raw[1]),
    .OUT0(dec_raw[0])
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= StIdle;
      sel_q     <= 3'd7;
      hold_q    <= '0;
      guard_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      hold_q    <= hold_d;
      guard_q   <= guard_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    hold_d    = hold_q;
    guard_d   = guard_q;
    timeout_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (REQ != '0) begin
          sel_d   = rr_pick(REQ, sel_q);
          hold_d  = '0;
          state_d = StGrant;
        end
      end
      StGrant: begin
        // A release wins over expiry, so a simultaneous drop never raises TIMEOUT.
        if (!REQ[sel_q]) begin
          guard_d = '0;
          state_d = StGuard;
        end else if (hold_q == HoldW'(MAX_HOLD - 1)) begin
          guard_d   = '0;
          timeout_d = 1'b1;
          state_d   = StGuard;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      StGuard: begin
        if (guard_q == GuardW'(GUARD_CYCLES - 1)) begin
          state_d = StIdle;
        end else begin
          guard_d = guard_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    GNT     = dec_raw & {N_REQ{state_q == StGrant}};
    SEL     = sel_q;
    BUSY    = (state_q == StGrant) || (state_q == StGuard);
    TIMEOUT = timeout_q;
  end

endmodule

// File: tb/tb_decoder_grant_arbiter.sv
// Directed bench for decoder_grant_arbiter with default parameters (MAX_HOLD=16, GUARD_CYCLES=1).
module tb_decoder_grant_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       busy;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  decoder_grant_arbiter #(
    .MAX_HOLD    (16),
    .GUARD_CYCLES(1)
  ) dut (
    .CLK    (clk),
    .RST_N  (rst_n),
    .REQ    (req),
    .GNT    (gnt),
    .SEL    (sel),
    .BUSY   (busy),
    .TIMEOUT(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] bit_k;

    // Reset with everyone requesting
    rst_n = 1'b0;
    req   = 8'hFF;
    @(negedge clk);
    @(negedge clk);
    check("rst_gnt", gnt, 8'h00);
    check("rst_sel", {5'd0, sel}, 8'h07);
    check("rst_busy", {7'd0, busy}, 8'h00);
    check("rst_timeout", {7'd0, timeout}, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_gnt", gnt, 8'h01);

    // Rotation: each winner holds two grant cycles, drops for its release edge, then re-raises
    for (int k = 0; k < 8; k++) begin
      bit_k = 8'h01 << k;
      check("rot_gnt_c1", gnt, bit_k);
      check("rot_sel", {5'd0, sel}, 8'(k));
      @(negedge clk);
      check("rot_gnt_c2", gnt, bit_k);
      req = 8'hFF & ~bit_k;
      @(negedge clk);
      check("rot_guard_gnt", gnt, 8'h00);
      check("rot_guard_busy", {7'd0, busy}, 8'h01);
      req = 8'hFF;
      @(negedge clk);
      check("rot_idle_gnt", gnt, 8'h00);
      check("rot_idle_busy", {7'd0, busy}, 8'h00);
      @(negedge clk);
    end
    check("rot_wrap_gnt", gnt, 8'h01);

    // Wrap: serve 5, then with 0 and 5 requesting, 0 goes first
    req = 8'h20;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("wrap_gnt5", gnt, 8'h20);
    check("wrap_sel5", {5'd0, sel}, 8'h05);
    req = 8'h01;
    @(negedge clk);
    req = 8'h21;
    @(negedge clk);
    @(negedge clk);
    check("wrap_gnt0", gnt, 8'h01);
    req = 8'h20;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("wrap_gnt5_again", gnt, 8'h20);

    // Timeout: sole requester 3 held high for 16 grant cycles
    req = 8'h08;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      check("to_hold_gnt", gnt, 8'h08);
      check("to_hold_timeout", {7'd0, timeout}, 8'h00);
      @(negedge clk);
    end
    check("to_cut_gnt", gnt, 8'h00);
    check("to_pulse", {7'd0, timeout}, 8'h01);
    check("to_guard_busy", {7'd0, busy}, 8'h01);
    @(negedge clk);
    check("to_pulse_end", {7'd0, timeout}, 8'h00);
    check("to_idle_gnt", gnt, 8'h00);
    @(negedge clk);
    check("to_regrant", gnt, 8'h08);

    // Drop on the same cycle the hold count expires: normal release
    for (int i = 0; i < 15; i++) @(negedge clk);
    check("sim_last_cycle_gnt", gnt, 8'h08);
    req = 8'h00;
    @(negedge clk);
    check("sim_release_gnt", gnt, 8'h00);
    check("sim_no_timeout", {7'd0, timeout}, 8'h00);
    check("sim_guard_busy", {7'd0, busy}, 8'h01);
    @(negedge clk);
    check("sim_idle_busy", {7'd0, busy}, 8'h00);
    check("sim_idle_timeout", {7'd0, timeout}, 8'h00);

    // Mid-grant asynchronous reset
    req = 8'h10;
    @(negedge clk);
    check("mid_gnt4", gnt, 8'h10);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_gnt", gnt, 8'h00);
    check("mid_rst_sel", {5'd0, sel}, 8'h07);
    check("mid_rst_busy", {7'd0, busy}, 8'h00);
    req = 8'h11;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_post_gnt", gnt, 8'h01);
    check("mid_post_sel", {5'd0, sel}, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
